inst_buffer: RTL and testbench

INST_BUFFER -- requirements
Module: inst_buffer

---
 rtl/inst_buffer.sv | 113 +++++++++++
 tb/tb_inst_buffer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/inst_buffer.sv
// rtl/inst_buffer.sv - fetch-to-decode instruction buffer, circular FIFO with multi-lane push/pop
module inst_buffer #(
  parameter int FETCH_WIDTH    = 2,
  parameter int ISSUE_WIDTH    = 2,
  parameter int DEPTH          = 8,
  parameter int ADDR_WIDTH     = 32,
  parameter int INST_WIDTH     = 32,
  parameter int EXCP_NUM_WIDTH = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic [FETCH_WIDTH-1:0]                 fetch_valid_i,
  input  logic [FETCH_WIDTH*ADDR_WIDTH-1:0]      fetch_pc_i,
  input  logic [FETCH_WIDTH*INST_WIDTH-1:0]      fetch_inst_i,
  input  logic [FETCH_WIDTH-1:0]                 fetch_excp_i,
  input  logic [FETCH_WIDTH*EXCP_NUM_WIDTH-1:0]  fetch_excp_num_i,
  output logic                                   fetch_ready_o,
  output logic [ISSUE_WIDTH-1:0]                 id_valid_o,
  output logic [ISSUE_WIDTH*ADDR_WIDTH-1:0]      id_pc_o,
  output logic [ISSUE_WIDTH*INST_WIDTH-1:0]      id_inst_o,
  output logic [ISSUE_WIDTH-1:0]                 id_excp_o,
  output logic [ISSUE_WIDTH*EXCP_NUM_WIDTH-1:0]  id_excp_num_o,
  input  logic [ISSUE_WIDTH-1:0]                 id_accept_i,
  output logic [$clog2(DEPTH+1)-1:0]             count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - FETCH_WIDTH);

  logic [ADDR_WIDTH-1:0]     pc_mem       [DEPTH];
  logic [INST_WIDTH-1:0]     inst_mem     [DEPTH];
  logic                      excp_mem     [DEPTH];
  logic [EXCP_NUM_WIDTH-1:0] excp_num_mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [CNT_W-1:0] push_cnt;
  logic [CNT_W-1:0] push_taken;
  logic [CNT_W-1:0] pop_cnt;
  logic             pop_run;
  logic [PTR_W-1:0] wr_idx [FETCH_WIDTH];

  // Readiness uses the registered count only, so same-cycle pops never raise it.
  assign fetch_ready_o = (count <= READY_MAX);
  assign count_o       = count;

  // Compaction: each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wr_idx[i] = tail + PTR_W'(push_cnt);
      if (fetch_valid_i[i]) begin
        push_cnt = push_cnt + CNT_W'(1);
      end
    end
  end

  assign push_taken = fetch_ready_o ? push_cnt : '0;

  always_comb begin
    pop_cnt = '0;
    pop_run = 1'b1;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      if (pop_run && id_accept_i[i] && id_valid_o[i]) begin
        pop_cnt = pop_cnt + CNT_W'(1);
      end else begin
        pop_run = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_cnt);
      tail  <= tail + PTR_W'(push_taken);
      count <= count + push_taken - pop_cnt;
    end
  end

  // Writes only touch free slots, so storage needs neither reset nor flush gating.
  always_ff @(posedge clk) begin
    if (fetch_ready_o) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (fetch_valid_i[i]) begin
          pc_mem[wr_idx[i]]       <= fetch_pc_i[i*ADDR_WIDTH +: ADDR_WIDTH];
          inst_mem[wr_idx[i]]     <= fetch_inst_i[i*INST_WIDTH +: INST_WIDTH];
          excp_mem[wr_idx[i]]     <= fetch_excp_i[i];
          excp_num_mem[wr_idx[i]] <= fetch_excp_num_i[i*EXCP_NUM_WIDTH +: EXCP_NUM_WIDTH];
        end
      end
    end
  end

  for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_out
    logic [PTR_W-1:0] rd_idx;
    assign rd_idx        = head + PTR_W'(g);
    assign id_valid_o[g] = (count > CNT_W'(g));
    assign id_pc_o[g*ADDR_WIDTH +: ADDR_WIDTH] = id_valid_o[g] ? pc_mem[rd_idx] : '0;
    assign id_inst_o[g*INST_WIDTH +: INST_WIDTH] = id_valid_o[g] ? inst_mem[rd_idx] : '0;
    assign id_excp_o[g] = id_valid_o[g] ? excp_mem[rd_idx] : 1'b0;
    assign id_excp_num_o[g*EXCP_NUM_WIDTH +: EXCP_NUM_WIDTH] =
      id_valid_o[g] ? excp_num_mem[rd_idx] : '0;
  end

endmodule

// File: tb/tb_inst_buffer.sv
// tb/tb_inst_buffer.sv - scoreboard bench for inst_buffer
module tb_inst_buffer;

  localparam int FW = 2;
  localparam int IW = 2;
  localparam int D  = 8;
  localparam int AW = 32;
  localparam int NW = 32;
  localparam int EW = 4;
  localparam logic [31:0] INST_KEY = 32'hDEAD_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [FW-1:0]     fetch_valid_i;
  logic [FW*AW-1:0]  fetch_pc_i;
  logic [FW*NW-1:0]  fetch_inst_i;
  logic [FW-1:0]     fetch_excp_i;
  logic [FW*EW-1:0]  fetch_excp_num_i;
  logic              fetch_ready_o;
  logic [IW-1:0]     id_valid_o;
  logic [IW*AW-1:0]  id_pc_o;
  logic [IW*NW-1:0]  id_inst_o;
  logic [IW-1:0]     id_excp_o;
  logic [IW*EW-1:0]  id_excp_num_o;
  logic [IW-1:0]     id_accept_i;
  logic [3:0]        count_o;

  inst_buffer #(
    .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(D),
    .ADDR_WIDTH(AW), .INST_WIDTH(NW), .EXCP_NUM_WIDTH(EW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_valid_i(fetch_valid_i), .fetch_pc_i(fetch_pc_i), .fetch_inst_i(fetch_inst_i),
    .fetch_excp_i(fetch_excp_i), .fetch_excp_num_i(fetch_excp_num_i),
    .fetch_ready_o(fetch_ready_o),
    .id_valid_o(id_valid_o), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
    .id_excp_o(id_excp_o), .id_excp_num_o(id_excp_num_o),
    .id_accept_i(id_accept_i), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
    logic [3:0]  en;
  } ent_t;

  ent_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
  endtask

  task automatic check_outputs();
    ent_t e;
    check("count", 64'(count_o), 64'(sb.size()));
    check("ready", 64'(fetch_ready_o), 64'((D - sb.size()) >= FW));
    for (int i = 0; i < IW; i++) begin
      e = (i < sb.size()) ? sb[i] : '0;
      check($sformatf("valid%0d", i), 64'(id_valid_o[i]), 64'(i < sb.size()));
      check($sformatf("pc%0d", i), 64'(id_pc_o[i*AW +: AW]), 64'(e.pc));
      check($sformatf("inst%0d", i), 64'(id_inst_o[i*NW +: NW]), 64'(e.inst));
      check($sformatf("excp%0d", i), 64'(id_excp_o[i]), 64'(e.excp));
      check($sformatf("excp_num%0d", i), 64'(id_excp_num_o[i*EW +: EW]), 64'(e.en));
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; flush = 1'b0;
    fetch_valid_i = '0; fetch_pc_i = '0; fetch_inst_i = '0;
    fetch_excp_i = '0; fetch_excp_num_i = '0; id_accept_i = '0;
  endtask

  // Check current state against the model, drive one cycle, then update the model.
  task automatic cycle(input logic [1:0] fv, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [1:0] ex, input logic [3:0] en, input logic [1:0] acc,
                       input logic fl, input logic rs);
    int   npop;
    bit   run;
    bit   rdy;
    ent_t e;
    check_outputs();
    rdy  = (D - sb.size()) >= FW;
    npop = 0;
    run  = 1'b1;
    for (int i = 0; i < IW; i++) begin
      if (run && acc[i] && i < sb.size()) npop++;
      else run = 1'b0;
    end
    rst = rs; flush = fl;
    fetch_valid_i = fv;
    fetch_pc_i = {p1, p0};
    fetch_inst_i = {p1 ^ INST_KEY, p0 ^ INST_KEY};
    fetch_excp_i = ex;
    fetch_excp_num_i = {en, en};
    id_accept_i = acc;
    @(posedge clk);
    #1;
    if (rs || fl) begin
      sb.delete();
    end else begin
      repeat (npop) void'(sb.pop_front());
      if (rdy) begin
        for (int i = 0; i < FW; i++) begin
          if (fv[i]) begin
            e.pc = (i == 0) ? p0 : p1;
            e.inst = e.pc ^ INST_KEY;
            e.excp = ex[i];
            e.en = en;
            sb.push_back(e);
          end
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // fill to full, then an ignored fifth group, then drain
    for (int k = 0; k < 4; k++) cycle(2'b11, 32'h1000, 32'h1004, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    cycle(2'b11, 32'h1100, 32'h1104, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cycle(2'b00, 0, 0, 2'b00, 4'h0, 2'b11, 1'b0, 1'b0);

    // partial lanes and accept gaps
    cycle(2'b10, 32'h0000_BAD0, 32'h2004, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    cycle(2'b11, 32'h2008, 32'h200C, 2'b00, 4'h0, 2'b01, 1'b0, 1'b0);
    cycle(2'b00, 0, 0, 2'b00, 4'h0, 2'b10, 1'b0, 1'b0);
    cycle(2'b00, 0, 0, 2'b00, 4'h0, 2'b01, 1'b0, 1'b0);
    cycle(2'b00, 0, 0, 2'b00, 4'h0, 2'b11, 1'b0, 1'b0);

    // streaming push/pop of two per cycle from an odd head, straddling the wrap
    cycle(2'b11, 32'h3000, 32'h3004, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++)
      cycle(2'b11, 32'h3000 + 32'(8*k), 32'h3004 + 32'(8*k), 2'b00, 4'h0, 2'b11, 1'b0, 1'b0);
    cycle(2'b00, 0, 0, 2'b00, 4'h0, 2'b11, 1'b0, 1'b0);

    // flush at count 6 with a push and full accept in the same cycle
    for (int k = 0; k < 3; k++)
      cycle(2'b11, 32'h4000 + 32'(8*k), 32'h4004 + 32'(8*k), 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    cycle(2'b11, 32'h4100, 32'h4104, 2'b00, 4'h0, 2'b11, 1'b1, 1'b0);

    // exception tag travels with the entry
    cycle(2'b01, 32'h5000, 32'h5004, 2'b01, 4'hA, 2'b00, 1'b0, 1'b0);
    cycle(2'b00, 0, 0, 2'b00, 4'h0, 2'b01, 1'b0, 1'b0);

    // reset at count 5 together with flush and a push
    cycle(2'b11, 32'h6000, 32'h6004, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    cycle(2'b11, 32'h6008, 32'h600C, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    cycle(2'b01, 32'h6010, 32'h6014, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    cycle(2'b11, 32'h6100, 32'h6104, 2'b11, 4'h3, 2'b11, 1'b1, 1'b1);
    cycle(2'b01, 32'h7000, 32'h7004, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    cycle(2'b00, 0, 0, 2'b00, 4'h0, 2'b01, 1'b0, 1'b0);
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
